// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the five-stage RV64I core, plus the EX-side
//   operand steering that feeds the ALU.
//
//   Captures the decoded instruction from ID and resolves rs1/rs2 forwarding
//   from MEM (priority) and WB. Drives ALU operands alu_a/alu_b and alu_op.
//   Detects load-use hazards and inserts one bubble per hazard. Honours a
//   global stall and a branch flush.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   stall, flush          global freeze / branch redirect (flush wins)
//   id_*                  decoded fields and regfile reads from ID
//   mem_rd/we/data        EX/MEM forwarding source
//   wb_rd/we/data         MEM/WB forwarding source (also regfile write port)
//   load_use_stall        hold PC and IF/ID this cycle (combinational)
//   ex_valid, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we
//                         registered instruction state seen by EX
//   alu_a, alu_b, alu_op  ALU operands and operation
//   ex_store_data         forwarded rs2, independent of src_b
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [3:0]      id_alu_op,
  input  logic            id_src_a,
  input  logic            id_src_b,
  input  logic            id_reg_we,
  input  logic            id_mem_re,
  input  logic            id_mem_we,
  input  logic [4:0]      mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data
);

  // Registered instruction state
  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic [3:0]      alu_op_q,   alu_op_d;
  logic            src_a_q,    src_a_d;
  logic            src_b_q,    src_b_d;
  logic            reg_we_q,   reg_we_d;
  logic            mem_re_q,   mem_re_d;
  logic            mem_we_q,   mem_we_d;

  // ---------------------------------------------------------------------------
  // Load-use hazard: the instruction in EX is a load whose destination is read
  // by the instruction in ID. A flush kills the ID instruction anyway, so no
  // hold is needed then.
  // ---------------------------------------------------------------------------
  logic hit_rs1, hit_rs2;
  assign hit_rs1 = id_use_rs1 && (id_rs1 == rd_q);
  assign hit_rs2 = id_use_rs2 && (id_rs2 == rd_q);

  assign load_use_stall = !flush && id_valid && valid_q && mem_re_q &&
                          (rd_q != 5'd0) && (hit_rs1 || hit_rs2);

  // ---------------------------------------------------------------------------
  // Write-through on capture: the regfile is written by WB in the same cycle
  // ID reads it, so the read data may be stale; take wb_data directly.
  // ---------------------------------------------------------------------------
  logic wt_rs1, wt_rs2;
  assign wt_rs1 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign wt_rs2 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2);

  // ---------------------------------------------------------------------------
  // Next-state selection: flush > stall > bubble > load
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_op_d   = alu_op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    reg_we_d   = reg_we_q;
    mem_re_d   = mem_re_q;
    mem_we_d   = mem_we_q;

    if (flush) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
      mem_re_d = 1'b0;
      mem_we_d = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (load_use_stall) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
      mem_re_d = 1'b0;
      mem_we_d = 1'b0;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = wt_rs1 ? wb_data : id_rs1_data;
      rs2_data_d = wt_rs2 ? wb_data : id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      alu_op_d   = id_alu_op;
      src_a_d    = id_src_a;
      src_b_d    = id_src_b;
      // Enables are qualified by valid so an empty EX slot never writes.
      reg_we_d   = id_reg_we & id_valid;
      mem_re_d   = id_mem_re & id_valid;
      mem_we_d   = id_mem_we & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      alu_op_q   <= 4'd0;
      src_a_q    <= 1'b0;
      src_b_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      reg_we_q   <= reg_we_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding: MEM is younger than WB, so it wins. x0 never forwards.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fwd1, fwd2;

  always_comb begin
    fwd1 = rs1_data_q;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
      fwd1 = mem_data;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
      fwd1 = wb_data;
    end
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
      fwd2 = mem_data;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
      fwd2 = wb_data;
    end
  end

  assign alu_a         = src_a_q ? pc_q  : fwd1;
  assign alu_b         = src_b_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign alu_op        = alu_op_q;

  assign ex_valid  = valid_q;
  assign ex_pc     = pc_q;
  assign ex_rd     = rd_q;
  assign ex_reg_we = reg_we_q;
  assign ex_mem_re = mem_re_q;
  assign ex_mem_we = mem_we_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: a table of single-instruction vectors
//   checked through an expected-value queue, plus hand-written sequences for
//   reset, load-use, stall/flush, write-through and mid-run reset.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN = 64;
  localparam int W    = 1 + XLEN + 5 + 3 + XLEN + XLEN + 4 + XLEN;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic            stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_use_rs1, id_use_rs2;
  logic [3:0]      id_alu_op;
  logic            id_src_a, id_src_b, id_reg_we, id_mem_re, id_mem_we;
  logic [4:0]      mem_rd, wb_rd;
  logic            mem_we, wb_we;
  logic [XLEN-1:0] mem_data, wb_data;
  logic            load_use_stall, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we;
  logic [XLEN-1:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [4:0]      ex_rd;
  logic [3:0]      alu_op;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_alu_op      (id_alu_op),
    .id_src_a       (id_src_a),
    .id_src_b       (id_src_b),
    .id_reg_we      (id_reg_we),
    .id_mem_re      (id_mem_re),
    .id_mem_we      (id_mem_we),
    .mem_rd         (mem_rd),
    .mem_we         (mem_we),
    .mem_data       (mem_data),
    .wb_rd          (wb_rd),
    .wb_we          (wb_we),
    .wb_data        (wb_data),
    .load_use_stall (load_use_stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rd          (ex_rd),
    .ex_reg_we      (ex_reg_we),
    .ex_mem_re      (ex_mem_re),
    .ex_mem_we      (ex_mem_we),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .ex_store_data  (ex_store_data)
  );

  logic [W-1:0] dut_out;
  assign dut_out = {ex_valid, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
                    alu_a, alu_b, alu_op, ex_store_data};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] pack(input logic v, input logic [XLEN-1:0] pc,
                                        input logic [4:0] rd, input logic we,
                                        input logic re, input logic swe,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b,
                                        input logic [3:0] op,
                                        input logic [XLEN-1:0] st);
    return {v, pc, rd, we, re, swe, a, b, op, st};
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [W-1:0] e, m;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if ((dut_out & m) !== (e & m)) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", name, dut_out & m, e & m);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid    = 1'b0;
    id_pc       = '0;
    id_rs1_data = '0;
    id_rs2_data = '0;
    id_imm      = '0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_rd       = 5'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    id_alu_op   = 4'd0;
    id_src_a    = 1'b0;
    id_src_b    = 1'b0;
    id_reg_we   = 1'b0;
    id_mem_re   = 1'b0;
    id_mem_we   = 1'b0;
  endtask

  task automatic fwd_clear();
    mem_rd   = 5'd0;
    mem_we   = 1'b0;
    mem_data = '0;
    wb_rd    = 5'd0;
    wb_we    = 1'b0;
    wb_data  = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      op;
    logic            sa, sb, we, re, swe;
    logic [4:0]      mrd;
    logic            mwe;
    logic [XLEN-1:0] mdata;
    logic [4:0]      wrd;
    logic            wwe;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp_a, exp_b, exp_st;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // plain register operands, no forwarding
    vecs[0] = '{1'b1, 64'h100, 64'h11, 64'h22, 64'h33, 5'd1, 5'd2, 5'd3, 4'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                64'h11, 64'h22, 64'h22};
    // pc / imm operands, reserved op code passes through
    vecs[1] = '{1'b1, 64'h2000, 64'h1, 64'h44, 64'hFFFF_FFFF_FFFF_FFF0,
                5'd1, 5'd2, 5'd4, 4'hF,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h44};
    // MEM and WB both match: MEM wins
    vecs[2] = '{1'b1, 64'h300, 64'h55, 64'h66, 64'h0, 5'd5, 5'd5, 5'd6, 4'h1,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                5'd5, 1'b1, 64'hAA, 5'd5, 1'b1, 64'hBB,
                64'hAA, 64'hAA, 64'hAA};
    // MEM not writing: WB wins
    vecs[3] = '{1'b1, 64'h304, 64'h55, 64'h66, 64'h0, 5'd5, 5'd5, 5'd6, 4'h1,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                5'd5, 1'b0, 64'hAA, 5'd5, 1'b1, 64'hBB,
                64'hBB, 64'hBB, 64'hBB};
    // x0 never forwards
    vecs[4] = '{1'b1, 64'h400, 64'h77, 64'h88, 64'h0, 5'd0, 5'd0, 5'd1, 4'h2,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                5'd0, 1'b1, 64'hAA, 5'd0, 1'b1, 64'hBB,
                64'h77, 64'h88, 64'h88};
    // split sources; store data forwarded although alu_b takes imm
    vecs[5] = '{1'b1, 64'h500, 64'h1, 64'h2, 64'h8, 5'd6, 5'd9, 5'd10, 4'h5,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                5'd9, 1'b1, 64'hCC, 5'd6, 1'b1, 64'hDD,
                64'hDD, 64'h8, 64'hCC};
    // invalid instruction: enables must read 0
    vecs[6] = '{1'b0, 64'h600, 64'h1, 64'h2, 64'h3, 5'd1, 5'd2, 5'd3, 4'h3,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                64'h0, 64'h0, 64'h0};
    // load+store enables, SRAW code
    vecs[7] = '{1'b1, 64'h700, 64'h12, 64'h34, 64'h56, 5'd11, 5'd12, 5'd13, 4'hE,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                5'd0, 1'b0, 64'h0, 5'd0, 1'b0, 64'h0,
                64'h12, 64'h34, 64'h34};
  end

  // ---------------------------------------------------------------------------
  // Main test
  // ---------------------------------------------------------------------------
  initial begin
    rstn  = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    id_clear();
    fwd_clear();

    // ---- reset release ----
    id_valid = 1'b1;
    id_pc    = 64'h1000;
    id_src_a = 1'b1;
    id_imm   = 64'h4;
    id_src_b = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_pc", ex_pc, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
    chk("rst_lus", {63'd0, load_use_stall}, 64'd0);
    rstn = 1'b1;
    tick();
    chk("rel_valid", {63'd0, ex_valid}, 64'd1);
    chk("rel_alu_a", alu_a, 64'h1000);
    chk("rel_alu_b", alu_b, 64'h4);

    // ---- table vectors ----
    for (int i = 0; i < 8; i++) begin
      id_clear();
      fwd_clear();
      id_valid    = vecs[i].valid;
      id_pc       = vecs[i].pc;
      id_rs1_data = vecs[i].rs1d;
      id_rs2_data = vecs[i].rs2d;
      id_imm      = vecs[i].imm;
      id_rs1      = vecs[i].rs1;
      id_rs2      = vecs[i].rs2;
      id_rd       = vecs[i].rd;
      id_alu_op   = vecs[i].op;
      id_src_a    = vecs[i].sa;
      id_src_b    = vecs[i].sb;
      id_reg_we   = vecs[i].we;
      id_mem_re   = vecs[i].re;
      id_mem_we   = vecs[i].swe;
      exp_q.push_back(pack(vecs[i].valid, vecs[i].pc, vecs[i].rd,
                           vecs[i].we & vecs[i].valid, vecs[i].re & vecs[i].valid,
                           vecs[i].swe & vecs[i].valid, vecs[i].exp_a,
                           vecs[i].exp_b, vecs[i].op, vecs[i].exp_st));
      msk_q.push_back(vecs[i].valid ? {W{1'b1}}
                      : pack(1'b1, '0, 5'd0, 1'b1, 1'b1, 1'b1, '0, '0, 4'd0, '0));
      tick();
      mem_rd   = vecs[i].mrd;
      mem_we   = vecs[i].mwe;
      mem_data = vecs[i].mdata;
      wb_rd    = vecs[i].wrd;
      wb_we    = vecs[i].wwe;
      wb_data  = vecs[i].wdata;
      #1;
      sb_check($sformatf("vec%0d", i));
    end
    fwd_clear();

    // ---- load-use hazard ----
    id_clear();
    id_valid = 1'b1; id_rd = 5'd7; id_mem_re = 1'b1; id_reg_we = 1'b1;
    id_pc = 64'h800;
    tick();
    id_clear();
    id_valid = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs2_data = 64'h999;
    id_rd = 5'd8; id_reg_we = 1'b1; id_pc = 64'h804;
    #1;
    chk("lu_stall", {63'd0, load_use_stall}, 64'd1);
    tick();
    chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
    chk("lu_bubble_re", {63'd0, ex_mem_re}, 64'd0);
    chk("lu_release", {63'd0, load_use_stall}, 64'd0);
    tick();
    mem_rd = 5'd7; mem_we = 1'b1; mem_data = 64'h1234;
    #1;
    chk("lu_cons_valid", {63'd0, ex_valid}, 64'd1);
    chk("lu_cons_rd", {59'd0, ex_rd}, 64'd8);
    chk("lu_cons_alu_b", alu_b, 64'h1234);
    chk("lu_cons_store", ex_store_data, 64'h1234);
    fwd_clear();

    // ---- no false hazard: rs2 not used ----
    id_clear();
    id_valid = 1'b1; id_rd = 5'd7; id_mem_re = 1'b1;
    tick();
    id_clear();
    id_valid = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b0; id_rd = 5'd9;
    #1;
    chk("nh_unused", {63'd0, load_use_stall}, 64'd0);
    tick();
    chk("nh_unused_valid", {63'd0, ex_valid}, 64'd1);
    chk("nh_unused_rd", {59'd0, ex_rd}, 64'd9);

    // ---- no false hazard: load to x0 ----
    id_clear();
    id_valid = 1'b1; id_rd = 5'd0; id_mem_re = 1'b1;
    tick();
    id_clear();
    id_valid = 1'b1; id_rs2 = 5'd0; id_use_rs2 = 1'b1; id_rd = 5'd10;
    #1;
    chk("nh_x0", {63'd0, load_use_stall}, 64'd0);
    tick();
    chk("nh_x0_rd", {59'd0, ex_rd}, 64'd10);

    // ---- stall freezes state ----
    id_clear();
    id_valid = 1'b1; id_pc = 64'hA0; id_rd = 5'd4; id_reg_we = 1'b1;
    id_src_a = 1'b1;
    tick();
    chk("st_pre_pc", ex_pc, 64'hA0);
    id_pc = 64'hB0; id_rd = 5'd5;
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("st_hold_pc%0d", c), ex_pc, 64'hA0);
      chk($sformatf("st_hold_rd%0d", c), {59'd0, ex_rd}, 64'd4);
      chk($sformatf("st_hold_a%0d", c), alu_a, 64'hA0);
    end
    stall = 1'b0;
    tick();
    chk("st_after_pc", ex_pc, 64'hB0);

    // ---- stall beats load-use; flush beats stall ----
    id_clear();
    id_valid = 1'b1; id_rd = 5'd7; id_mem_re = 1'b1; id_reg_we = 1'b1;
    tick();
    id_clear();
    id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_rd = 5'd12;
    id_reg_we = 1'b1;
    stall = 1'b1;
    #1;
    chk("sl_lus", {63'd0, load_use_stall}, 64'd1);
    tick();
    chk("sl_lus_held", {63'd0, load_use_stall}, 64'd1);
    chk("sl_re_held", {63'd0, ex_mem_re}, 64'd1);
    chk("sl_rd_held", {59'd0, ex_rd}, 64'd7);
    flush = 1'b1;
    #1;
    chk("fl_lus_forced", {63'd0, load_use_stall}, 64'd0);
    tick();
    chk("fl_valid", {63'd0, ex_valid}, 64'd0);
    chk("fl_reg_we", {63'd0, ex_reg_we}, 64'd0);
    chk("fl_mem_re", {63'd0, ex_mem_re}, 64'd0);
    flush = 1'b0;
    stall = 1'b0;
    tick();
    chk("fl_next_valid", {63'd0, ex_valid}, 64'd1);
    chk("fl_next_rd", {59'd0, ex_rd}, 64'd12);

    // ---- write-through on capture ----
    id_clear();
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_data = 64'h11;
    id_rs2 = 5'd3; id_rs2_data = 64'h33;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'h22;
    tick();
    fwd_clear();
    #1;
    chk("wt_alu_a", alu_a, 64'h22);
    chk("wt_store", ex_store_data, 64'h22);

    // ---- asynchronous reset mid-run ----
    id_clear();
    id_valid = 1'b1; id_pc = 64'hC0; id_reg_we = 1'b1;
    tick();
    rstn = 1'b0;
    #1;
    chk("mr_valid", {63'd0, ex_valid}, 64'd0);
    chk("mr_pc", ex_pc, 64'd0);
    chk("mr_reg_we", {63'd0, ex_reg_we}, 64'd0);
    id_pc = 64'hD0;
    #2;
    rstn = 1'b1;
    tick();
    chk("mr_load_valid", {63'd0, ex_valid}, 64'd1);
    chk("mr_load_pc", ex_pc, 64'hD0);

    // ---- final report ----
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
